// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller
//   Sequences register->register and immediate->register moves over the
//   shared tri-state data bus. Two requesters are arbitrated round-robin.
//   Every legal move is DRIVE (bus settle), then LATCH (destination loads),
//   then RELEASE (turnaround, done pulse). An illegal move goes straight to
//   RELEASE with error set and never asserts an enable.
// Ports
//   controller_clock / controller_reset : clock, synchronous active-high reset
//   reqN_valid/src/src_imm/imm/dst      : transfer request from requester N
//   reqN_ready                          : combinational accept strobe
//   reg_out_en / reg_in_en              : one-hot register bus drive / load
//   imm_out_en / imm_data               : immediate buffer drive and value
//   busy, done, done_id, error          : status (done_id/error valid with done)
module bus_transfer_controller #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 16
) (
  input  logic                controller_clock,
  input  logic                controller_reset,
  input  logic                req0_valid,
  input  logic [SEL_W-1:0]    req0_src,
  input  logic                req0_src_imm,
  input  logic [DATA_W-1:0]   req0_imm,
  input  logic [SEL_W-1:0]    req0_dst,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [SEL_W-1:0]    req1_src,
  input  logic                req1_src_imm,
  input  logic [DATA_W-1:0]   req1_imm,
  input  logic [SEL_W-1:0]    req1_dst,
  output logic                req1_ready,
  output logic [NUM_REGS-1:0] reg_out_en,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic                imm_out_en,
  output logic [DATA_W-1:0]   imm_data,
  output logic                busy,
  output logic                done,
  output logic                done_id,
  output logic                error
);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, RELEASE} state_e;

  localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [SEL_W-1:0]    src_q, src_d, dst_q, dst_d;
  logic                src_imm_q, src_imm_d, id_q, id_d, err_q, err_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [NUM_REGS-1:0] out_en_q, out_en_d, in_en_q, in_en_d;
  logic                imm_en_q, imm_en_d, done_q, done_d;
  logic                done_id_q, done_id_d, error_q, error_d;

  logic                grant, accept, illegal, drive_ph;
  logic [SEL_W-1:0]    sel_src, sel_dst;
  logic                sel_imm;
  logic [DATA_W-1:0]   sel_val;

  // Arbitration: a lone requester wins; on contention the one that did not
  // win last time gets the bus.
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept     = (state_q == IDLE) && (req0_valid || req1_valid) && !controller_reset;
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    sel_src    = grant ? req1_src     : req0_src;
    sel_dst    = grant ? req1_dst     : req0_dst;
    sel_imm    = grant ? req1_src_imm : req0_src_imm;
    sel_val    = grant ? req1_imm     : req0_imm;
    illegal    = (!sel_imm && ((sel_src == sel_dst) || ({1'b0, sel_src} >= NREGS)))
                 || ({1'b0, sel_dst} >= NREGS);
  end

  // Next state plus next value of every registered output. Enables are
  // decoded from the post-edge state and fields so they appear exactly in
  // the cycle the state is entered.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    dst_d        = dst_q;
    src_imm_d    = src_imm_q;
    id_d         = id_q;
    err_d        = err_q;
    imm_d        = imm_q;
    case (state_q)
      IDLE: if (accept) begin
        src_d        = sel_src;
        dst_d        = sel_dst;
        src_imm_d    = sel_imm;
        id_d         = grant;
        err_d        = illegal;
        last_grant_d = grant;
        if (sel_imm) imm_d = sel_val;
        state_d      = illegal ? RELEASE : DRIVE;
      end
      DRIVE:   state_d = LATCH;
      LATCH:   state_d = RELEASE;
      default: state_d = IDLE;
    endcase

    drive_ph = (state_d == DRIVE) || (state_d == LATCH);
    for (int i = 0; i < NUM_REGS; i++) begin
      out_en_d[i] = drive_ph && !src_imm_d && (src_d == SEL_W'(i));
      in_en_d[i]  = (state_d == LATCH) && (dst_d == SEL_W'(i));
    end
    imm_en_d  = drive_ph && src_imm_d;
    done_d    = (state_d == RELEASE);
    done_id_d = (state_d == RELEASE) && id_d;
    error_d   = (state_d == RELEASE) && err_d;
  end

  always_ff @(posedge controller_clock) begin
    if (controller_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      src_q        <= '0;
      dst_q        <= '0;
      src_imm_q    <= 1'b0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      imm_q        <= '0;
      out_en_q     <= '0;
      in_en_q      <= '0;
      imm_en_q     <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      src_imm_q    <= src_imm_d;
      id_q         <= id_d;
      err_q        <= err_d;
      imm_q        <= imm_d;
      out_en_q     <= out_en_d;
      in_en_q      <= in_en_d;
      imm_en_q     <= imm_en_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      error_q      <= error_d;
    end
  end

  assign reg_out_en = out_en_q;
  assign reg_in_en  = in_en_q;
  assign imm_out_en = imm_en_q;
  assign imm_data   = imm_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign error      = error_q;

endmodule

// File: tb/tb_bus_transfer_controller.sv
module tb_bus_transfer_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, i0, v1, i1;
  logic [1:0]  s0, d0, s1, d1;
  logic [15:0] m0, m1;
  logic        rdy0, rdy1, imo, bsy, dn, did, er;
  logic [3:0]  oe, ie;
  logic [15:0] imd;

  always #5 clk = ~clk;

  bus_transfer_controller #(.NUM_REGS(4), .SEL_W(2), .DATA_W(16)) dut (
    .controller_clock(clk), .controller_reset(rst),
    .req0_valid(v0), .req0_src(s0), .req0_src_imm(i0), .req0_imm(m0), .req0_dst(d0),
    .req0_ready(rdy0),
    .req1_valid(v1), .req1_src(s1), .req1_src_imm(i1), .req1_imm(m1), .req1_dst(d1),
    .req1_ready(rdy1),
    .reg_out_en(oe), .reg_in_en(ie), .imm_out_en(imo), .imm_data(imd),
    .busy(bsy), .done(dn), .done_id(did), .error(er)
  );

  typedef struct {
    logic        rst, v0, v1, i0, i1;
    logic [1:0]  s0, d0, s1, d1;
    logic [15:0] m0, m1;
    logic [30:0] exp;  // {rdy0,rdy1,oe,ie,imo,imd,busy,done,done_id,error}
  } vec_t;

  vec_t        tbl[$];
  vec_t        cur;
  int          n_vec = 0, n_err = 0;
  logic [30:0] got;

  function automatic logic [30:0] e(input int r0, r1, o, n, im, id, b, dd, di, ee);
    return {r0[0], r1[0], o[3:0], n[3:0], im[0], id[15:0], b[0], dd[0], di[0], ee[0]};
  endfunction

  task automatic set_r0(input int s, i, m, d);
    cur.s0 = s[1:0]; cur.i0 = i[0]; cur.m0 = m[15:0]; cur.d0 = d[1:0];
  endtask
  task automatic set_r1(input int s, i, m, d);
    cur.s1 = s[1:0]; cur.i1 = i[0]; cur.m1 = m[15:0]; cur.d1 = d[1:0];
  endtask
  task automatic row(input int r, a0, a1, input logic [30:0] x);
    cur.rst = r[0]; cur.v0 = a0[0]; cur.v1 = a1[0]; cur.exp = x;
    tbl.push_back(cur);
  endtask

  initial begin
    int acc, dones;
    // Each row is one cycle: inputs held during the cycle, outputs expected
    // during that same cycle (after the previous rising edge).
    set_r0(1, 0, 0, 3); set_r1(0, 0, 0, 0);
    row(0, 0, 0, e(0,0,0,0,0,0,0,0,0,0));                     // reset state
    // R1 -> R3 on req0, valid held throughout
    row(0, 1, 0, e(1,0,0,0,0,0,0,0,0,0));                     // T0 accept
    set_r0(2, 0, 0, 3);                                       // late change ignored
    row(0, 1, 0, e(0,0,'b0010,0,0,0,1,0,0,0));                // T1 DRIVE
    row(0, 1, 0, e(0,0,'b0010,'b1000,0,0,1,0,0,0));           // T2 LATCH
    row(0, 1, 0, e(0,0,0,0,0,0,1,1,0,0));                     // T3 RELEASE
    row(0, 0, 0, e(0,0,0,0,0,0,0,0,0,0));
    // immediate 0xBEEF -> R2 on req1, single-cycle valid
    set_r1(0, 1, 'hBEEF, 2);
    row(0, 0, 1, e(0,1,0,0,0,0,0,0,0,0));
    row(0, 0, 0, e(0,0,0,0,1,'hBEEF,1,0,0,0));
    row(0, 0, 0, e(0,0,0,'b0100,1,'hBEEF,1,0,0,0));
    row(0, 0, 0, e(0,0,0,0,0,'hBEEF,1,1,1,0));
    row(0, 0, 0, e(0,0,0,0,0,'hBEEF,0,0,0,0));                // imm_data holds
    // illegal R2 -> R2, issued twice back to back
    set_r0(2, 0, 0, 2);
    row(0, 1, 0, e(1,0,0,0,0,'hBEEF,0,0,0,0));
    row(0, 1, 0, e(0,0,0,0,0,'hBEEF,1,1,0,1));
    row(0, 1, 0, e(1,0,0,0,0,'hBEEF,0,0,0,0));                // accept 2 cycles later
    row(0, 0, 0, e(0,0,0,0,0,'hBEEF,1,1,0,1));
    row(0, 0, 0, e(0,0,0,0,0,'hBEEF,0,0,0,0));
    // contention from reset: req0 R0->R1, req1 imm 0x1234 -> R3
    set_r0(0, 0, 0, 1); set_r1(0, 1, 'h1234, 3);
    row(1, 1, 1, e(0,0,0,0,0,'hBEEF,0,0,0,0));                // no ready in reset
    row(0, 1, 1, e(1,0,0,0,0,0,0,0,0,0));
    row(0, 1, 1, e(0,0,'b0001,0,0,0,1,0,0,0));
    row(0, 1, 1, e(0,0,'b0001,'b0010,0,0,1,0,0,0));
    row(0, 1, 1, e(0,0,0,0,0,0,1,1,0,0));
    row(0, 1, 1, e(0,1,0,0,0,0,0,0,0,0));
    row(0, 1, 1, e(0,0,0,0,1,'h1234,1,0,0,0));
    row(0, 1, 1, e(0,0,0,'b1000,1,'h1234,1,0,0,0));
    row(0, 1, 1, e(0,0,0,0,0,'h1234,1,1,1,0));
    row(0, 1, 1, e(1,0,0,0,0,'h1234,0,0,0,0));
    row(0, 1, 1, e(0,0,'b0001,0,0,'h1234,1,0,0,0));
    row(0, 1, 1, e(0,0,'b0001,'b0010,0,'h1234,1,0,0,0));
    row(0, 1, 1, e(0,0,0,0,0,'h1234,1,1,0,0));
    row(0, 1, 1, e(0,1,0,0,0,'h1234,0,0,0,0));
    row(0, 1, 1, e(0,0,0,0,1,'h1234,1,0,0,0));
    // reset while in LATCH: enables drop, no done, req0 wins next
    row(1, 1, 1, e(0,0,0,'b1000,1,'h1234,1,0,0,0));
    row(0, 1, 1, e(1,0,0,0,0,0,0,0,0,0));
    row(0, 1, 1, e(0,0,'b0001,0,0,0,1,0,0,0));
    row(0, 1, 1, e(0,0,'b0001,'b0010,0,0,1,0,0,0));
    row(0, 1, 1, e(0,0,0,0,0,0,1,1,0,0));
    row(0, 0, 0, e(0,0,0,0,0,0,0,0,0,0));

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    s0 = '0; d0 = '0; i0 = 1'b0; m0 = '0;
    s1 = '0; d1 = '0; i1 = 1'b0; m1 = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst; v0 = tbl[k].v0; v1 = tbl[k].v1;
      s0 = tbl[k].s0; d0 = tbl[k].d0; i0 = tbl[k].i0; m0 = tbl[k].m0;
      s1 = tbl[k].s1; d1 = tbl[k].d1; i1 = tbl[k].i1; m1 = tbl[k].m1;
      #1;
      got = {rdy0, rdy1, oe, ie, imo, imd, bsy, dn, did, er};
      n_vec++;
      if (got !== tbl[k].exp) begin
        n_err++;
        $display("FAIL row %0d {rdy0,rdy1,oe,ie,imo,imd,busy,done,id,err}: got %b exp %b",
                 k, got, tbl[k].exp);
      end
    end

    // random traffic: bus invariants every cycle, every accept finishes
    acc = 0; dones = 0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if (c < 400) begin
        v0 = ($urandom_range(0, 1) == 1); v1 = ($urandom_range(0, 1) == 1);
      end else begin
        v0 = 1'b0; v1 = 1'b0;
      end
      s0 = 2'($urandom_range(0, 3)); d0 = 2'($urandom_range(0, 3));
      s1 = 2'($urandom_range(0, 3)); d1 = 2'($urandom_range(0, 3));
      i0 = ($urandom_range(0, 3) == 0); i1 = ($urandom_range(0, 3) == 0);
      m0 = 16'($urandom); m1 = 16'($urandom);
      #1;
      if (v0 && rdy0) acc++;
      if (v1 && rdy1) acc++;
      if (dn) dones++;
      n_vec++;
      if ($countones({oe, imo}) > 1 || $countones(ie) > 1 ||
          (ie != 0 && {oe, imo} == 5'b0) ||
          (dn && ({oe, ie, imo} != 9'b0)) || (rdy0 && rdy1) ||
          (er && !dn) || (dn != bsy && dn)) begin
        n_err++;
        $display("FAIL invariant cyc %0d: oe=%b ie=%b imo=%b rdy=%b%b done=%b err=%b busy=%b",
                 c, oe, ie, imo, rdy0, rdy1, dn, er, bsy);
      end
    end
    n_vec++;
    if (acc != dones) begin
      n_err++;
      $display("FAIL accept/done count: got %0d dones, exp %0d", dones, acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
